gcd_driver: RTL and testbench
=============================

# gcd_driver

Operand sequencer and result collector for the `Gcd` engine. Queues up to DEPTH operand pairs and drives them onto `Gcd`'s `d1`/`d2` one pair at a time. Restarts the engine through its reset input, waits for `finished_flag`, and stores each `gcd` result in a readable buffer. It sits between a host or test controller and `Gcd`, replacing hand-written stimulus sequencing.

## Interface
- WIDTH, 16, operand/result width (matches `Gcd` `d1`/`d2`/`gcd`)
- DEPTH, 4, operand queue and result buffer entries (power of two)
- LOAD_CYC, 2, cycles `gcd_rst` is held high with operands stable
- TIMEOUT, 1024, max cycles waiting for `finished_flag` (used only with timeout feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  host offers an operand pair
- ld_a  in  WIDTH  first operand
- ld_b  in  WIDTH  second operand
- ld_ready  out  1  pair accepted when ld_valid && ld_ready
- start  in  1  single-cycle pulse; process all queued pairs
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the batch completes
- res_cnt  out  $clog2(DEPTH)+1  number of valid results in buffer
- rd_idx  in  $clog2(DEPTH)  result read address
- rd_data  out  WIDTH  result at rd_idx, registered
- timeout_flag  out  1  sticky; a pair timed out (timeout feature only, else tied 0)
- d1  out  WIDTH  to `Gcd.d1`
- d2  out  WIDTH  to `Gcd.d2`
- gcd_rst  out  1  to `Gcd.rst`; high = engine held/reloaded
- gcd  in  WIDTH  from `Gcd.gcd`
- finished_flag  in  1  from `Gcd.finished_flag`

## Operation
- Reset values:
  - ld_ready=1, busy=0, done=0, res_cnt=0, rd_data=0, timeout_flag=0, d1=0, d2=0, gcd_rst=1.
  - Queue and result pointers cleared.
- Loading:
  - ld_ready = !busy && queue not full.
  - An accepted pair is written at the queue tail the same edge.
  - ld_valid while not ready: ignored, no state change.
- FSM states: IDLE, LOAD, RUN, STORE, FIN.
  - IDLE: start while queue non-empty -> LOAD; res_cnt cleared; busy=1.
  - IDLE: start with empty queue -> FIN (done after 1 cycle, res_cnt=0).
  - IDLE: start while busy -> ignored.
  - LOAD: d1/d2 = queue head; gcd_rst=1 for LOAD_CYC cycles -> RUN.
  - RUN: gcd_rst=0; d1/d2 held stable. A rising edge on finished_flag (registered previous value, so a level left high from the prior pair is not counted) -> STORE.
  - STORE: gcd written to result[res_cnt]; res_cnt++; queue head popped. Queue non-empty -> LOAD, else -> FIN.
  - FIN: done=1 for one cycle; busy=0; gcd_rst=1 -> IDLE.
- rd_data: updates on the clock edge after rd_idx changes. Reading an index >= res_cnt returns stale or zero data, not an error.
- Operands are passed through unmodified; zero operands are the engine's concern.
- Reset mid-batch: all state lost, outputs return to reset values, queue emptied.

## Timing
- Pair acceptance to queue: 0 cycles (same edge).
- start edge -> busy=1 and LOAD entered at the next edge.
- Per pair: LOAD_CYC + engine latency + 1 (edge detect) + 1 (STORE) cycles.
- Last STORE -> done pulse on the following cycle.
- start in the same cycle as a load handshake: both take effect; the new pair is included in the batch.

## Configuration
- GCD_DRIVER_TIMEOUT_EN defined:
  - A RUN-state counter is enabled.
  - If it reaches TIMEOUT without a finished_flag edge, the FSM goes to STORE and writes result 0.
  - timeout_flag is set and stays set until rst.
- Undefined: no counter; RUN waits indefinitely; timeout_flag tied 0.

## Structure
- Package gcd_pkg: state enum (IDLE/LOAD/RUN/STORE/FIN), default WIDTH/DEPTH constants, operand-pair struct {a, b}.
- One sub-module: gcd_pair_fifo (DEPTH-entry synchronous FIFO with full/empty). Result buffer and FSM stay in gcd_driver.

## Test plan
- Load (78,114), (77,35); start -> results [6, 7], res_cnt=2, single done pulse, gcd_rst high LOAD_CYC cycles before each pair.
- Load 4 pairs (full): ld_ready=0; a 5th ld_valid is ignored; batch yields (12,18)->6, (17,5)->1, (100,75)->25, (9,9)->9.
- start with empty queue -> done exactly 2 cycles after start, res_cnt=0, gcd_rst never deasserted.
- finished_flag held high across pairs -> the second pair waits for a fresh rising edge; no double store.
- Assert rst during RUN of pair 2 of 3 -> all outputs at reset values the same cycle; queue empty; next batch (48,36) -> 12.
- With GCD_DRIVER_TIMEOUT_EN and finished_flag stuck 0 -> after TIMEOUT cycles the result is 0, timeout_flag=1, batch continues, done asserted.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the Gcd engine driver.
package gcd_pkg;

  localparam int unsigned GcdWidth = 16;
  localparam int unsigned GcdDepth = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StStore,
    StFin
  } gcd_state_e;

  typedef struct packed {
    logic [GcdWidth-1:0] a;
    logic [GcdWidth-1:0] b;
  } gcd_pair_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous operand-pair FIFO with head and one-ahead lookahead read ports.
module gcd_pair_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_head,
  output logic [Width-1:0] o_head_nxt,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_multi
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW-1:0]  w_count;
  logic [AddrW-1:0] w_rnxt;

  assign w_count    = r_wptr - r_rptr;
  assign w_rnxt     = r_rptr[AddrW-1:0] + AddrW'(1);
  assign o_head     = r_mem[r_rptr[AddrW-1:0]];
  assign o_head_nxt = r_mem[w_rnxt];
  assign o_full     = (w_count == PtrW'(Depth));
  assign o_empty    = (w_count == '0);
  assign o_multi    = (w_count > PtrW'(1));

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr[AddrW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PtrW'(1);
      if (i_pop)  r_rptr <= r_rptr + PtrW'(1);
    end
  end

endmodule

// File: rtl/gcd_driver.sv
// Operand sequencer and result collector for the Gcd engine.
// Define GCD_DRIVER_TIMEOUT_EN to bound each wait for finished_flag to TIMEOUT cycles.
module gcd_driver
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = GcdWidth,
  parameter int unsigned DEPTH    = GcdDepth,
  parameter int unsigned LOAD_CYC = 2,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  input  logic [WIDTH-1:0]         ld_a,
  input  logic [WIDTH-1:0]         ld_b,
  output logic                     ld_ready,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   res_cnt,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     timeout_flag,
  output logic [WIDTH-1:0]         d1,
  output logic [WIDTH-1:0]         d2,
  output logic                     gcd_rst,
  input  logic [WIDTH-1:0]         gcd,
  input  logic                     finished_flag
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned CycW  = $clog2(LOAD_CYC) + 1;
  localparam int unsigned PairW = 2 * WIDTH;

  gcd_state_e       r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_gcd_rst;
  logic             r_fin_prev;
  logic [CycW-1:0]  r_cyc;
  logic [CntW-1:0]  r_res_cnt;
  logic [WIDTH-1:0] r_res_val;
  logic [WIDTH-1:0] r_d1;
  logic [WIDTH-1:0] r_d2;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_results [DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_multi;
  logic             w_fin_rise;
  logic [PairW-1:0] w_head;
  logic [PairW-1:0] w_head_nxt;
  logic [PairW-1:0] w_first;

  assign ld_ready   = !r_busy && !w_full;
  assign w_push     = ld_valid && ld_ready;
  assign w_pop      = (r_state == StStore);
  assign w_fin_rise = finished_flag && !r_fin_prev;
  // A pair loaded in the same cycle as start is the head when the queue was empty.
  assign w_first    = w_empty ? {ld_a, ld_b} : w_head;

  gcd_pair_fifo #(
    .Width(PairW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wdata   ({ld_a, ld_b}),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_head_nxt(w_head_nxt),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_multi   (w_multi)
  );

`ifdef GCD_DRIVER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT) + 1;
  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_tmo_flag;
  assign timeout_flag = r_tmo_flag;
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gcd_rst  <= 1'b1;
      r_fin_prev <= 1'b0;
      r_cyc      <= '0;
      r_res_cnt  <= '0;
      r_res_val  <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
`ifdef GCD_DRIVER_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_tmo_flag <= 1'b0;
`endif
    end else begin
      r_fin_prev <= finished_flag;
      r_done     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_res_cnt <= '0;
            if (!w_empty || w_push) begin
              r_state <= StLoad;
              r_d1    <= w_first[PairW-1:WIDTH];
              r_d2    <= w_first[WIDTH-1:0];
              r_cyc   <= '0;
            end else begin
              r_state <= StFin;
            end
          end
        end
        StLoad: begin
          if (r_cyc == CycW'(LOAD_CYC - 1)) begin
            r_state   <= StRun;
            r_gcd_rst <= 1'b0;
`ifdef GCD_DRIVER_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end else begin
            r_cyc <= r_cyc + CycW'(1);
          end
        end
        StRun: begin
          if (w_fin_rise) begin
            r_state   <= StStore;
            r_res_val <= gcd;
          end
`ifdef GCD_DRIVER_TIMEOUT_EN
          else if (r_tmo_cnt == TmoW'(TIMEOUT - 1)) begin
            r_state    <= StStore;
            r_res_val  <= '0;
            r_tmo_flag <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
          end
`endif
        end
        StStore: begin
          r_res_cnt <= r_res_cnt + CntW'(1);
          r_gcd_rst <= 1'b1;
          // The head is popped this edge, so the next pair comes from the lookahead port.
          if (w_multi) begin
            r_state <= StLoad;
            r_d1    <= w_head_nxt[PairW-1:WIDTH];
            r_d2    <= w_head_nxt[WIDTH-1:0];
            r_cyc   <= '0;
          end else begin
            r_state <= StFin;
          end
        end
        StFin: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_results[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (r_state == StStore) begin
        r_results[r_res_cnt[AddrW-1:0]] <= r_res_val;
      end
      r_rd_data <= r_results[rd_idx];
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign res_cnt = r_res_cnt;
  assign rd_data = r_rd_data;
  assign d1      = r_d1;
  assign d2      = r_d2;
  assign gcd_rst = r_gcd_rst;

endmodule

// File: tb/tb_gcd_driver.sv
// Bench for gcd_driver with a behavioural Euclid engine and a result scoreboard.
module tb_gcd_driver;

  localparam int unsigned W   = 16;
  localparam int unsigned D   = 4;
  localparam int unsigned LC  = 2;
  localparam int unsigned TMO = 64;
  localparam int unsigned AW  = $clog2(D);
  localparam int unsigned CW  = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic [W-1:0]  ld_a;
  logic [W-1:0]  ld_b;
  logic          ld_ready;
  logic          start;
  logic          busy;
  logic          done;
  logic [CW-1:0] res_cnt;
  logic [AW-1:0] rd_idx;
  logic [W-1:0]  rd_data;
  logic          timeout_flag;
  logic [W-1:0]  d1;
  logic [W-1:0]  d2;
  logic          gcd_rst;
  logic [W-1:0]  gcd;
  logic          finished_flag;

  logic          fin_ovr;
  logic          fin_val;
  logic [W-1:0]  m_x;
  logic [W-1:0]  m_y;
  logic          m_fin;

  int            n_checks;
  int            n_pass;
  logic [W-1:0]  exp_q[$];
  logic [2*W-1:0] seen_ops[$];

  always #5 clk = ~clk;

  gcd_driver #(
    .WIDTH   (W),
    .DEPTH   (D),
    .LOAD_CYC(LC),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_a         (ld_a),
    .ld_b         (ld_b),
    .ld_ready     (ld_ready),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .res_cnt      (res_cnt),
    .rd_idx       (rd_idx),
    .rd_data      (rd_data),
    .timeout_flag (timeout_flag),
    .d1           (d1),
    .d2           (d2),
    .gcd_rst      (gcd_rst),
    .gcd          (gcd),
    .finished_flag(finished_flag)
  );

  // Engine: one Euclid step per cycle; finished stays high until reloaded.
  always @(posedge clk) begin
    if (gcd_rst) begin
      m_x   <= d1;
      m_y   <= d2;
      m_fin <= 1'b0;
    end else if (m_y != '0) begin
      m_x <= m_y;
      m_y <= m_x % m_y;
    end else begin
      m_fin <= 1'b1;
    end
  end
  assign gcd           = m_x;
  assign finished_flag = fin_ovr ? fin_val : m_fin;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e, input string nm);
    n_checks++;
    if (ld_ready !== 1'b1) $display("FAIL %s ld_ready=%b want 1", nm, ld_ready);
    else n_pass++;
    ld_valid = 1'b1;
    ld_a     = a;
    ld_b     = b;
    tick();
    ld_valid = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic monitor_batch(input int budget, output int cyc, output int n_done,
                               output int n_runs, output int bad_runs, output bit low_seen,
                               output bit busy_at_done);
    int run;
    cyc = 0; n_done = 0; n_runs = 0; bad_runs = 0; low_seen = 1'b0; busy_at_done = 1'b1;
    run = 0;
    seen_ops.delete();
    for (int k = 1; k <= budget; k++) begin
      if (busy && gcd_rst) run++;
      if (!gcd_rst) begin
        low_seen = 1'b1;
        if (run != 0) begin
          n_runs++;
          if (run != int'(LC)) bad_runs++;
          seen_ops.push_back({d1, d2});
          run = 0;
        end
      end
      if (done) begin
        n_done++;
        if (cyc == 0) begin
          cyc          = k;
          busy_at_done = busy;
        end
      end
      if (cyc != 0 && k >= cyc + 3) break;
      tick();
    end
  endtask

  task automatic drain(input string nm, input int n);
    logic [W-1:0] want;
    n_checks++;
    if (res_cnt !== CW'(n)) $display("FAIL %s res_cnt=%0d want %0d", nm, res_cnt, n);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      rd_idx = AW'(i);
      tick();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (rd_data !== want) $display("FAIL %s result[%0d]=%0d want %0d", nm, i, rd_data, want);
      else n_pass++;
    end
  endtask

  task automatic wait_run(input string nm);
    int k;
    for (k = 0; k < 200; k++) begin
      if (busy && !gcd_rst) break;
      tick();
    end
    n_checks++;
    if (k == 200) $display("FAIL %s RUN not reached in 200 cycles", nm);
    else n_pass++;
  endtask

  task automatic wait_res(input string nm, input int n);
    int k;
    for (k = 0; k < 200; k++) begin
      if (res_cnt == CW'(n)) break;
      tick();
    end
    n_checks++;
    if (k == 200) $display("FAIL %s res_cnt=%0d never reached %0d", nm, res_cnt, n);
    else n_pass++;
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      if (done) break;
      tick();
    end
    n_checks++;
    if (k == 300) $display("FAIL %s done not seen in 300 cycles", nm);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; ld_valid = 1'b0; ld_a = '0; ld_b = '0; start = 1'b0; rd_idx = '0;
    fin_ovr = 1'b0; fin_val = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({ld_ready, busy, done, timeout_flag, gcd_rst} !== 5'b10001)
      $display("FAIL reset_flags ready/busy/done/tmo/gcd_rst=%b want 10001",
               {ld_ready, busy, done, timeout_flag, gcd_rst});
    else n_pass++;
    n_checks++;
    if (res_cnt !== '0 || rd_data !== '0) $display("FAIL reset_data res_cnt=%0d rd_data=%0d want 0",
                                                   res_cnt, rd_data);
    else n_pass++;
    n_checks++;
    if (d1 !== '0 || d2 !== '0) $display("FAIL reset_ops d1=%0d d2=%0d want 0", d1, d2);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, nd, nr, bad;
    bit low, bd;
    load_pair(16'd78, 16'd114, 16'd6, "basic_ld0");
    load_pair(16'd77, 16'd35, 16'd7, "basic_ld1");
    pulse_start();
    monitor_batch(300, cyc, nd, nr, bad, low, bd);
    n_checks++;
    if (cyc == 0 || nd != 1) $display("FAIL basic_done pulses=%0d want 1", nd);
    else n_pass++;
    n_checks++;
    if (nr != 2 || bad != 0) $display("FAIL basic_gcd_rst runs=%0d bad_len=%0d want 2/0", nr, bad);
    else n_pass++;
    n_checks++;
    if (seen_ops.size() != 2 || seen_ops[0] !== {16'd78, 16'd114} || seen_ops[1] !== {16'd77, 16'd35})
      $display("FAIL basic_ops got %0d pairs, first=%h want 004e0072 and 004d0023",
               seen_ops.size(), (seen_ops.size() != 0) ? seen_ops[0] : '0);
    else n_pass++;
    n_checks++;
    if (bd !== 1'b0) $display("FAIL basic_busy busy_at_done=%b want 0", bd);
    else n_pass++;
    drain("basic", 2);
  endtask

  task automatic test_full();
    int cyc, nd, nr, bad;
    bit low, bd;
    load_pair(16'd12, 16'd18, 16'd6, "full_ld0");
    load_pair(16'd17, 16'd5, 16'd1, "full_ld1");
    load_pair(16'd100, 16'd75, 16'd25, "full_ld2");
    load_pair(16'd9, 16'd9, 16'd9, "full_ld3");
    n_checks++;
    if (ld_ready !== 1'b0) $display("FAIL full_ready ld_ready=%b want 0", ld_ready);
    else n_pass++;
    ld_valid = 1'b1; ld_a = 16'd99; ld_b = 16'd3;
    tick();
    ld_valid = 1'b0;
    pulse_start();
    monitor_batch(600, cyc, nd, nr, bad, low, bd);
    n_checks++;
    if (cyc == 0 || nd != 1 || nr != 4) $display("FAIL full_batch done=%0d runs=%0d want 1/4", nd, nr);
    else n_pass++;
    drain("full", 4);
  endtask

  task automatic test_empty();
    int cyc, nd, nr, bad;
    bit low, bd;
    pulse_start();
    monitor_batch(20, cyc, nd, nr, bad, low, bd);
    n_checks++;
    if (cyc != 2 || nd != 1) $display("FAIL empty_done at=%0d pulses=%0d want 2/1", cyc, nd);
    else n_pass++;
    n_checks++;
    if (low !== 1'b0) $display("FAIL empty_gcd_rst low_seen=%b want 0", low);
    else n_pass++;
    drain("empty", 0);
  endtask

  task automatic test_back_to_back();
    int cyc, nd, nr, bad;
    bit low, bd;
    load_pair(16'd5, 16'd10, 16'd5, "b2b_ld0");
    ld_valid = 1'b1; ld_a = 16'd21; ld_b = 16'd14; start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    exp_q.push_back(16'd7);
    monitor_batch(300, cyc, nd, nr, bad, low, bd);
    n_checks++;
    if (cyc == 0 || nd != 1 || nr != 2) $display("FAIL b2b_batch done=%0d runs=%0d want 1/2", nd, nr);
    else n_pass++;
    drain("b2b", 2);
  endtask

  task automatic test_fin_hold();
    fin_ovr = 1'b1; fin_val = 1'b0;
    load_pair(16'd12, 16'd18, 16'd6, "hold_ld0");
    load_pair(16'd20, 16'd8, 16'd4, "hold_ld1");
    pulse_start();
    wait_run("hold_run1");
    repeat (10) tick();
    fin_val = 1'b1;
    wait_res("hold_store1", 1);
    wait_run("hold_run2");
    repeat (20) tick();
    n_checks++;
    if (res_cnt !== CW'(1) || busy !== 1'b1)
      $display("FAIL hold_no_double res_cnt=%0d busy=%b want 1/1", res_cnt, busy);
    else n_pass++;
    fin_val = 1'b0;
    tick();
    fin_val = 1'b1;
    wait_done("hold_done");
    fin_ovr = 1'b0;
    drain("hold", 2);
  endtask

  task automatic test_reset_mid();
    int cyc, nd, nr, bad;
    bit low, bd;
    load_pair(16'd30, 16'd12, 16'd6, "mid_ld0");
    load_pair(16'd40, 16'd15, 16'd5, "mid_ld1");
    load_pair(16'd50, 16'd20, 16'd10, "mid_ld2");
    pulse_start();
    wait_res("mid_store1", 1);
    wait_run("mid_run2");
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ld_ready, busy, done, gcd_rst} !== 4'b1001)
      $display("FAIL mid_rst_flags ready/busy/done/gcd_rst=%b want 1001",
               {ld_ready, busy, done, gcd_rst});
    else n_pass++;
    n_checks++;
    if (res_cnt !== '0 || d1 !== '0 || d2 !== '0 || rd_data !== '0)
      $display("FAIL mid_rst_data res_cnt=%0d d1=%0d d2=%0d rd_data=%0d want 0",
               res_cnt, d1, d2, rd_data);
    else n_pass++;
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    load_pair(16'd48, 16'd36, 16'd12, "mid_ld3");
    pulse_start();
    monitor_batch(300, cyc, nd, nr, bad, low, bd);
    n_checks++;
    if (cyc == 0 || nr != 1) $display("FAIL mid_after runs=%0d done_at=%0d want 1 run", nr, cyc);
    else n_pass++;
    drain("mid_after", 1);
  endtask

`ifdef GCD_DRIVER_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    fin_ovr = 1'b1; fin_val = 1'b0;
    load_pair(16'd8, 16'd4, 16'd0, "tmo_ld0");
    load_pair(16'd9, 16'd6, 16'd3, "tmo_ld1");
    pulse_start();
    wait_run("tmo_run1");
    for (k = 0; k < int'(TMO) + 50; k++) begin
      if (timeout_flag) break;
      tick();
    end
    n_checks++;
    if (k != int'(TMO)) $display("FAIL tmo_latency cycles=%0d want %0d", k, TMO);
    else n_pass++;
    fin_ovr = 1'b0;
    wait_done("tmo_done");
    n_checks++;
    if (timeout_flag !== 1'b1) $display("FAIL tmo_flag timeout_flag=%b want 1", timeout_flag);
    else n_pass++;
    drain("tmo", 2);
  endtask
`else
  task automatic test_timeout();
    n_checks++;
    if (timeout_flag !== 1'b0) $display("FAIL tmo_tied timeout_flag=%b want 0", timeout_flag);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_full();
    test_empty();
    test_back_to_back();
    test_fin_hold();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
